// File: rtl/space_saving_ctrl_pkg.sv
// Shared definitions for the Space-Saving CAM sequencing controller.
package space_saving_ctrl_pkg;

  // Controller state encoding (fixed values kept for legacy compatibility)
  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_SEARCH = 3'd2;
  localparam logic [2:0] ST_SCAN   = 3'd3;
  localparam logic [2:0] ST_INSERT = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

endpackage

// File: rtl/space_saving_ctrl_if.sv
// Request/response handshake plus the CAM strobe/match bus of the controller.
interface space_saving_ctrl_if #(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned ENTRY_WIDTH = 7,
  parameter int unsigned COUNT_WIDTH = 16
);
  logic                   req_valid;
  logic                   req_ready;
  logic [WORD_SIZE-1:0]   req_key;
  logic                   clear;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_hit;
  logic                   rsp_evicted;
  logic [ENTRY_WIDTH-1:0] rsp_addr;
  logic [COUNT_WIDTH-1:0] rsp_count;
  logic [WORD_SIZE-1:0]   cam_data_in;
  logic [ENTRY_WIDTH-1:0] cam_addr_in;
  logic                   cam_read_en;
  logic                   cam_write_en;
  logic                   cam_search_en;
  logic                   cam_reset;
  logic                   cam_match;
  logic [ENTRY_WIDTH-1:0] cam_addr_out;

  modport master (
    input  req_valid, req_key, clear, rsp_ready, cam_match, cam_addr_out,
    output req_ready, rsp_valid, rsp_hit, rsp_evicted, rsp_addr, rsp_count,
           cam_data_in, cam_addr_in, cam_read_en, cam_write_en, cam_search_en, cam_reset
  );

  modport slave (
    output req_valid, req_key, clear, rsp_ready, cam_match, cam_addr_out,
    input  req_ready, rsp_valid, rsp_hit, rsp_evicted, rsp_addr, rsp_count,
           cam_data_in, cam_addr_in, cam_read_en, cam_write_en, cam_search_en, cam_reset
  );
endinterface

// File: rtl/space_saving_ctrl_min_scan.sv
// Sequential minimum finder: walks every entry once, ties keep the lowest index.
module ss_min_scan #(
  parameter int unsigned ROW_NUM     = 68,
  parameter int unsigned ENTRY_WIDTH = 7,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] count_in,
  output logic [ENTRY_WIDTH-1:0] scan_idx,
  output logic                   done,
  output logic [ENTRY_WIDTH-1:0] min_idx,
  output logic [COUNT_WIDTH-1:0] min_val
);
  localparam logic [ENTRY_WIDTH-1:0] LAST_IDX = ENTRY_WIDTH'(ROW_NUM - 1);

  logic                   active;
  logic [ENTRY_WIDTH-1:0] idx_r;
  logic [COUNT_WIDTH-1:0] run_val;
  logic [ENTRY_WIDTH-1:0] run_idx;
  logic                   take;

  // Running minimum including the entry presented this cycle, so the
  // result is final in the same cycle the last entry is examined.
  always_comb begin
    take    = (idx_r == '0) || (count_in < run_val);
    min_val = take ? count_in : run_val;
    min_idx = take ? idx_r : run_idx;
    done    = active && (idx_r == LAST_IDX);
  end

  assign scan_idx = idx_r;

  // Step through the entries, folding each into the running minimum
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active  <= 1'b0;
      idx_r   <= '0;
      run_val <= '0;
      run_idx <= '0;
    end else if (start) begin
      active <= 1'b1;
      idx_r  <= '0;
    end else if (active) begin
      run_val <= min_val;
      run_idx <= min_idx;
      if (idx_r == LAST_IDX) begin
        active <= 1'b0;
      end else begin
        idx_r <= idx_r + ENTRY_WIDTH'(1);
      end
    end
  end
endmodule

// File: rtl/space_saving_ctrl.sv
// Space-Saving heavy-hitter controller: CAM sequencing plus per-entry counts.
module space_saving_ctrl
  import space_saving_ctrl_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned ENTRY_WIDTH = 7,
  parameter int unsigned ROW_NUM     = 68,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  space_saving_ctrl_if.master bus
);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);
  localparam logic [ENTRY_WIDTH:0]   FILL_FULL = (ENTRY_WIDTH + 1)'(ROW_NUM);

  logic [2:0]             state;
  logic [WORD_SIZE-1:0]   key_r;
  logic [ENTRY_WIDTH-1:0] target_r;
  logic [COUNT_WIDTH-1:0] new_cnt_r;
  logic                   evict_r;
  logic [ENTRY_WIDTH:0]   fill_cnt;
  logic [COUNT_WIDTH-1:0] count [ROW_NUM];

  logic                   rsp_hit_r;
  logic                   rsp_evicted_r;
  logic [ENTRY_WIDTH-1:0] rsp_addr_r;
  logic [COUNT_WIDTH-1:0] rsp_count_r;

  logic [COUNT_WIDTH-1:0] hit_cnt;
  logic [COUNT_WIDTH-1:0] hit_inc;
  logic [COUNT_WIDTH-1:0] scan_cnt;
  logic [COUNT_WIDTH-1:0] min_inc;
  logic                   scan_start;
  logic                   scan_done;
  logic [ENTRY_WIDTH-1:0] scan_idx;
  logic [ENTRY_WIDTH-1:0] min_idx;
  logic [COUNT_WIDTH-1:0] min_val;

  ss_min_scan #(
    .ROW_NUM     (ROW_NUM),
    .ENTRY_WIDTH (ENTRY_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_min_scan (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (scan_start),
    .count_in (scan_cnt),
    .scan_idx (scan_idx),
    .done     (scan_done),
    .min_idx  (min_idx),
    .min_val  (min_val)
  );

  // Saturating increments for the hit entry and the evicted minimum
  always_comb begin
    hit_cnt    = count[bus.cam_addr_out];
    hit_inc    = (hit_cnt == COUNT_MAX) ? COUNT_MAX : hit_cnt + COUNT_ONE;
    scan_cnt   = count[scan_idx];
    min_inc    = (min_val == COUNT_MAX) ? COUNT_MAX : min_val + COUNT_ONE;
    scan_start = (state == ST_SEARCH) && !bus.cam_match && (fill_cnt >= FILL_FULL);
  end

  // Handshake and CAM strobes decoded straight from the state
  always_comb begin
    bus.req_ready     = (state == ST_IDLE);
    bus.rsp_valid     = (state == ST_RESP);
    bus.cam_reset     = (state == ST_INIT);
    bus.cam_search_en = (state == ST_SEARCH);
    bus.cam_write_en  = (state == ST_INSERT);
    bus.cam_read_en   = 1'b0;
    bus.cam_data_in   = ((state == ST_SEARCH) || (state == ST_INSERT)) ? key_r : '0;
    bus.cam_addr_in   = (state == ST_INSERT) ? target_r : '0;
    bus.rsp_hit       = rsp_hit_r;
    bus.rsp_evicted   = rsp_evicted_r;
    bus.rsp_addr      = rsp_addr_r;
    bus.rsp_count     = rsp_count_r;
  end

  // Per-entry count registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < ROW_NUM; i++) count[i] <= '0;
    end else begin
      case (state)
        ST_INIT:   for (int unsigned i = 0; i < ROW_NUM; i++) count[i] <= '0;
        ST_SEARCH: if (bus.cam_match) count[bus.cam_addr_out] <= hit_inc;
        ST_INSERT: count[target_r] <= new_cnt_r;
        default:   ;
      endcase
    end
  end

  // Request sequencing FSM and response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_INIT;
      key_r         <= '0;
      target_r      <= '0;
      new_cnt_r     <= '0;
      evict_r       <= 1'b0;
      fill_cnt      <= '0;
      rsp_hit_r     <= 1'b0;
      rsp_evicted_r <= 1'b0;
      rsp_addr_r    <= '0;
      rsp_count_r   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          fill_cnt <= '0;
          state    <= ST_IDLE;
        end
        ST_IDLE: begin
          if (bus.clear) begin
            state <= ST_INIT;
          end else if (bus.req_valid) begin
            key_r <= bus.req_key;
            state <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (bus.cam_match) begin
            rsp_hit_r     <= 1'b1;
            rsp_evicted_r <= 1'b0;
            rsp_addr_r    <= bus.cam_addr_out;
            rsp_count_r   <= hit_inc;
            state         <= ST_RESP;
          end else if (fill_cnt < FILL_FULL) begin
            target_r  <= fill_cnt[ENTRY_WIDTH-1:0];
            new_cnt_r <= COUNT_ONE;
            evict_r   <= 1'b0;
            state     <= ST_INSERT;
          end else begin
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (scan_done) begin
            target_r  <= min_idx;
            new_cnt_r <= min_inc;
            evict_r   <= 1'b1;
            state     <= ST_INSERT;
          end
        end
        ST_INSERT: begin
          if (!evict_r) fill_cnt <= fill_cnt + (ENTRY_WIDTH + 1)'(1);
          rsp_hit_r     <= 1'b0;
          rsp_evicted_r <= evict_r;
          rsp_addr_r    <= target_r;
          rsp_count_r   <= new_cnt_r;
          state         <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_space_saving_ctrl.sv
// Directed bench for space_saving_ctrl with a behavioural CAM attached.
module tb_space_saving_ctrl;
  localparam int WS = 16;
  localparam int EW = 7;
  localparam int RN = 68;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  space_saving_ctrl_if #(.WORD_SIZE(WS), .ENTRY_WIDTH(EW), .COUNT_WIDTH(CW)) bus ();

  space_saving_ctrl #(
    .WORD_SIZE   (WS),
    .ENTRY_WIDTH (EW),
    .ROW_NUM     (RN),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural CAM: clocked write/clear, combinational lowest-index match
  logic [WS-1:0] cam_key [RN];
  logic          cam_vld [RN];

  always_ff @(posedge clk) begin
    if (bus.cam_reset) begin
      for (int i = 0; i < RN; i++) cam_vld[i] <= 1'b0;
    end else if (bus.cam_write_en) begin
      cam_key[bus.cam_addr_in] <= bus.cam_data_in;
      cam_vld[bus.cam_addr_in] <= 1'b1;
    end
  end

  always_comb begin
    bus.cam_match    = 1'b0;
    bus.cam_addr_out = '0;
    if (bus.cam_search_en) begin
      for (int i = RN - 1; i >= 0; i--) begin
        if (cam_vld[i] && cam_key[i] == bus.cam_data_in) begin
          bus.cam_match    = 1'b1;
          bus.cam_addr_out = EW'(i);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [WS-1:0] key, input logic e_hit, input logic e_ev,
                        input int e_addr, input int e_cnt, input int e_lat, input int hold);
    int lat;
    int guard;
    guard = 0;
    while (!bus.req_ready && guard < 10) begin
      step();
      guard++;
    end
    chk("req_ready_before_accept", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_key   = key;
    step();
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 200) begin
      step();
      lat++;
    end
    chk("latency", lat, e_lat);
    chk("rsp_hit", 32'(bus.rsp_hit), 32'(e_hit));
    chk("rsp_evicted", 32'(bus.rsp_evicted), 32'(e_ev));
    chk("rsp_addr", 32'(bus.rsp_addr), e_addr);
    chk("rsp_count", 32'(bus.rsp_count), e_cnt);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("hold_req_ready", 32'(bus.req_ready), 0);
      chk("hold_rsp_addr", 32'(bus.rsp_addr), e_addr);
      chk("hold_rsp_count", 32'(bus.rsp_count), e_cnt);
      chk("hold_rsp_evicted", 32'(bus.rsp_evicted), 32'(e_ev));
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_released", 32'(bus.rsp_valid), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_valid;
    bus.req_valid = 1'b0;
    bus.req_key   = '0;
    bus.clear     = 1'b0;
    bus.rsp_ready = 1'b0;

    // Reset held: CAM clear asserted, no handshake activity
    step();
    step();
    chk("rst_cam_reset", 32'(bus.cam_reset), 1);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_search_en", 32'(bus.cam_search_en), 0);
    chk("rst_write_en", 32'(bus.cam_write_en), 0);
    chk("rst_read_en", 32'(bus.cam_read_en), 0);
    reset_n = 1'b1;
    #1;
    chk("init_cam_reset", 32'(bus.cam_reset), 1);
    step();
    chk("idle_cam_reset", 32'(bus.cam_reset), 0);
    chk("idle_req_ready", 32'(bus.req_ready), 1);
    chk("idle_rsp_valid", 32'(bus.rsp_valid), 0);

    // Insert into empty table, then hit it
    do_req(16'hABCD, 1'b0, 1'b0, 0, 1, 3, 0);
    do_req(16'hABCD, 1'b1, 1'b0, 0, 2, 2, 0);

    // clear and req_valid together: clear wins
    bus.clear     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_key   = 16'h5555;
    step();
    bus.clear     = 1'b0;
    bus.req_valid = 1'b0;
    chk("clear_cam_reset", 32'(bus.cam_reset), 1);
    chk("clear_req_ready", 32'(bus.req_ready), 0);
    chk("clear_no_search", 32'(bus.cam_search_en), 0);
    step();
    chk("clear_back_idle", 32'(bus.req_ready), 1);

    // Fill the table with 68 distinct keys
    for (int i = 1; i <= RN; i++) do_req(16'(i), 1'b0, 1'b0, i - 1, 1, 3, 0);

    // Full-table miss: all counts 1, tie resolves to entry 0
    do_req(16'h9999, 1'b0, 1'b1, 0, 2, RN + 3, 0);

    // Key 0x0002 lives at entry 1 with count 1; hit until saturated at 15
    for (int n = 1; n <= 15; n++) do_req(16'h0002, 1'b1, 1'b0, 1, (n + 1 > 15) ? 15 : n + 1, 2, 0);

    // Counts now e0=2, e1=15, rest 1: eviction picks entry 2; hold response 5 cycles
    do_req(16'h7777, 1'b0, 1'b1, 2, 2, RN + 3, 5);

    // Reset asserted while scanning
    bus.req_valid = 1'b1;
    bus.req_key   = 16'h8888;
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    reset_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("midrst_req_ready", 32'(bus.req_ready), 0);
    chk("midrst_cam_reset", 32'(bus.cam_reset), 1);
    chk("midrst_rsp_addr", 32'(bus.rsp_addr), 0);
    chk("midrst_rsp_count", 32'(bus.rsp_count), 0);
    chk("midrst_rsp_evicted", 32'(bus.rsp_evicted), 0);
    seen_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.rsp_valid) seen_valid++;
    end
    reset_n = 1'b1;
    #1;
    chk("postrst_cam_reset", 32'(bus.cam_reset), 1);
    for (int i = 0; i < RN + 5; i++) begin
      step();
      if (bus.rsp_valid) seen_valid++;
    end
    chk("postrst_no_response", seen_valid, 0);
    chk("postrst_req_ready", 32'(bus.req_ready), 1);

    // Table emptied: a previously resident key misses and lands at entry 0
    do_req(16'h0004, 1'b0, 1'b0, 0, 1, 3, 0);
    do_req(16'h0004, 1'b1, 1'b0, 0, 2, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
